// File: rtl/bitwise_logic_unit_pkg.sv
// Shared types for the bitwise logic unit: operation codes and burst state.
// Imported by the operation core and the top level.
package logic_unit_pkg;

   typedef enum logic [2:0] {
      OP_AND    = 3'd0,
      OP_OR     = 3'd1,
      OP_XOR    = 3'd2,
      OP_NAND   = 3'd3,
      OP_NOR    = 3'd4,
      OP_XNOR   = 3'd5,
      OP_NOT_X  = 3'd6,
      OP_PASS_X = 3'd7
   } op_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_e;

endpackage

// File: rtl/bitwise_logic_unit_op.sv
// Combinational bitwise operation core shared by first and continuation beats.
// Unary operations act on operand a, which always carries the incoming X beat.
module bitwise_op
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  op_e              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      case (op)
         OP_AND:    y = a & b;
         OP_OR:     y = a | b;
         OP_XOR:    y = a ^ b;
         OP_NAND:   y = ~(a & b);
         OP_NOR:    y = ~(a | b);
         OP_XNOR:   y = ~(a ^ b);
         OP_NOT_X:  y = ~a;
         OP_PASS_X: y = a;
         default:   y = '0;
      endcase
   end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Registered bitwise logic unit with valid/ready handshake and multi-beat
// accumulate (reduction) bursts.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | next accepted beat is a first beat (operates on X and Y)
// ST_ACCUM | burst open; beats fold X into acc with the latched OP
//
// The output register (out_valid/OUT/ZERO/BEAT_CNT) is independent of the
// burst state, so a burst may start while the previous result drains.
module bitwise_logic_unit
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic [2:0]       OP,
   input  logic             ACC,
   input  logic             LAST,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] OUT,
   output logic             ZERO,
   output logic [CNT_W-1:0] BEAT_CNT
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             zero_q, zero_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             out_valid_q, out_valid_d;

   logic             in_burst;
   logic             accept;
   logic             finish;
   op_e              op_sel;
   logic [WIDTH-1:0] opnd_b;
   logic [WIDTH-1:0] op_y;
   logic [CNT_W-1:0] cnt_next;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign in_burst = (state_q == ST_ACCUM);

   // X always drives operand a so unary ops see X on every beat; binary ops
   // are symmetric, so (acc, X) and (X, acc) give the same result.
   assign op_sel = in_burst ? op_q : op_e'(OP);
   assign opnd_b = in_burst ? acc_q : Y;

   bitwise_op #(
      .WIDTH (WIDTH)
   ) u_op (
      .op (op_sel),
      .a  (X),
      .b  (opnd_b),
      .y  (op_y)
   );

   assign cnt_next = !in_burst ? CNT_ONE :
                     (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

   assign finish = accept && (in_burst ? LAST : (!ACC || LAST));

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      zero_d      = zero_q;
      beat_cnt_d  = beat_cnt_q;
      out_valid_d = out_valid_q;

      if (accept) begin
         acc_d   = op_y;
         cnt_d   = cnt_next;
         state_d = finish ? ST_IDLE : ST_ACCUM;
         if (!in_burst) begin
            op_d = op_e'(OP);
         end
      end

      if (finish) begin
         out_d       = op_y;
         zero_d      = (op_y == '0);
         beat_cnt_d  = cnt_next;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_AND;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_q       <= '0;
         zero_q      <= 1'b0;
         beat_cnt_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         zero_q      <= zero_d;
         beat_cnt_q  <= beat_cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign OUT       = out_q;
   assign ZERO      = zero_q;
   assign BEAT_CNT  = beat_cnt_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Scoreboard bench: two units (CNT_W=4 and CNT_W=2) share one stimulus stream;
// a list-based reference model predicts results, a monitor checks them.
module tb_bitwise_logic_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       out_ready;
   logic [7:0] X, Y;
   logic [2:0] OP;
   logic       ACC, LAST;

   logic       in_ready, out_valid, ZERO;
   logic [7:0] OUT;
   logic [3:0] BEAT_CNT;
   logic       s_in_ready, s_out_valid, s_ZERO;
   logic [7:0] s_OUT;
   logic [1:0] s_BEAT_CNT;

   int n_checks = 0;
   int n_fail   = 0;
   bit rnd_ready_en = 1'b0;

   typedef struct {
      logic [7:0] val;
      int         cnt;
   } exp_t;
   exp_t exp_q[$];

   bit         m_in_burst = 1'b0;
   int         m_op;
   logic [7:0] m_first;
   logic [7:0] m_xs[$];

   always #5 clk = ~clk;

   bitwise_logic_unit #(.WIDTH(8), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .X(X), .Y(Y), .OP(OP), .ACC(ACC), .LAST(LAST),
      .out_valid(out_valid), .out_ready(out_ready),
      .OUT(OUT), .ZERO(ZERO), .BEAT_CNT(BEAT_CNT)
   );

   bitwise_logic_unit #(.WIDTH(8), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .X(X), .Y(Y), .OP(OP), .ACC(ACC), .LAST(LAST),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .OUT(s_OUT), .ZERO(s_ZERO), .BEAT_CNT(s_BEAT_CNT)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Unary ops take the newest X; binary ops combine the two values.
   function automatic logic [7:0] ref_op(input int op, input logic [7:0] p,
                                          input logic [7:0] q, input logic [7:0] newest);
      case (op)
         0: return p & q;
         1: return p | q;
         2: return p ^ q;
         3: return ~(p & q);
         4: return ~(p | q);
         5: return ~(p ^ q);
         6: return ~newest;
         default: return newest;
      endcase
   endfunction

   function automatic int sat(input int c, input int m);
      return (c > m) ? m : c;
   endfunction

   // Observer: every accepted beat feeds the reference model.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_in_burst = 1'b0;
         m_xs.delete();
         exp_q.delete();
      end else if (in_valid && in_ready) begin
         if (!m_in_burst) begin
            if (!ACC || LAST) begin
               exp_q.push_back('{val: ref_op(int'(OP), X, Y, X), cnt: 1});
            end else begin
               m_in_burst = 1'b1;
               m_op       = int'(OP);
               m_first    = ref_op(int'(OP), X, Y, X);
               m_xs.delete();
            end
         end else begin
            m_xs.push_back(X);
            if (LAST) begin
               logic [7:0] v;
               v = m_first;
               foreach (m_xs[i]) v = ref_op(m_op, v, m_xs[i], m_xs[i]);
               exp_q.push_back('{val: v, cnt: 1 + m_xs.size()});
               m_in_burst = 1'b0;
            end
         end
      end
   end

   // Monitor: compares the presented result with the oldest expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready_rule", in_ready, !out_valid || out_ready);
         chk("sat_out_valid", s_out_valid, out_valid);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out_valid", out_valid, 1'b0);
            end else begin
               chk("OUT", OUT, exp_q[0].val);
               chk("ZERO", ZERO, exp_q[0].val == 8'h00);
               chk("BEAT_CNT", BEAT_CNT, sat(exp_q[0].cnt, 15));
               chk("sat_OUT", s_OUT, exp_q[0].val);
               chk("sat_BEAT_CNT", s_BEAT_CNT, sat(exp_q[0].cnt, 3));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rnd_ready_en) begin
         #1 out_ready = ($urandom % 4) != 0;
      end
   end

   task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op,
                       input logic acc, input logic last);
      int n;
      in_valid = 1'b1;
      X = x; Y = y; OP = op; ACC = acc; LAST = last;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 1000);
      if (!in_ready) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      X = '0; Y = '0; OP = '0; ACC = 1'b0; LAST = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_OUT", OUT, 0);
      chk("rst_ZERO", ZERO, 0);
      chk("rst_BEAT_CNT", BEAT_CNT, 0);
      chk("rst_in_ready", in_ready, 1);

      // Reset during the second beat of a burst
      @(posedge clk); #1;
      send(8'h12, 8'h34, 3'd1, 1'b1, 1'b0);
      in_valid = 1'b1; X = 8'h55; ACC = 1'b0; LAST = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 in_valid = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_OUT", OUT, 0);
      chk("abort_BEAT_CNT", BEAT_CNT, 0);
      chk("abort_in_ready", in_ready, 1);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;

      send(8'hA0, 8'h0F, 3'd1, 1'b0, 1'b0);
      chk("or_valid", out_valid, 1);
      chk("or_OUT", OUT, 8'hAF);
      chk("or_ZERO", ZERO, 0);
      chk("or_BEAT_CNT", BEAT_CNT, 1);

      // Continuation beats carry junk OP/ACC/Y that must be ignored
      send(8'h0F, 8'hF0, 3'd2, 1'b1, 1'b0);
      send(8'hFF, 8'h5A, 3'd0, 1'b0, 1'b0);
      send(8'h0F, 8'hC3, 3'd7, 1'b1, 1'b1);
      chk("xor_OUT", OUT, 8'h0F);
      chk("xor_BEAT_CNT", BEAT_CNT, 3);

      send(8'h0F, 8'hF0, 3'd0, 1'b0, 1'b0);
      chk("and_zero_ZERO", ZERO, 1);

      @(posedge clk); #1;
      out_ready = 1'b0;
      send(8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0);
      in_valid = 1'b1; X = 8'h11; Y = 8'h22; OP = 3'd1; ACC = 1'b0; LAST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_OUT", OUT, 8'h30);
         chk("bp_out_valid", out_valid, 1);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", in_ready, 1);
      @(posedge clk); #1 in_valid = 1'b0;
      chk("bp_second_OUT", OUT, 8'h33);

      send(8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0);
      chk("b2b_first_OUT", OUT, 8'h30);
      send(8'h00, 8'h00, 3'd4, 1'b0, 1'b0);
      chk("b2b_second_OUT", OUT, 8'hFF);
      chk("b2b_second_valid", out_valid, 1);
      chk("b2b_second_ZERO", ZERO, 0);

      send(8'hFF, 8'h81, 3'd0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) send(8'hFF, 8'h00, 3'd0, 1'b0, 1'b0);
      send(8'hFF, 8'h00, 3'd0, 1'b0, 1'b1);
      chk("sat_burst_OUT", s_OUT, 8'h81);
      chk("sat_burst_BEAT_CNT", s_BEAT_CNT, 3);
      chk("wide_burst_BEAT_CNT", BEAT_CNT, 5);

      rnd_ready_en = 1'b1;
      for (int b = 0; b < 300; b++) begin
         int len;
         logic [2:0] op0;
         op0 = 3'($urandom_range(0, 7));
         if ($urandom % 2) begin
            send(8'($urandom), 8'($urandom), op0, 1'b0, 1'($urandom));
         end else if ($urandom % 8 == 0) begin
            send(8'($urandom), 8'($urandom), op0, 1'b1, 1'b1);
         end else begin
            len = $urandom_range(2, 20);
            send(8'($urandom), 8'($urandom), op0, 1'b1, 1'b0);
            for (int k = 1; k < len; k++) begin
               send(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), k == len - 1);
            end
         end
         if ($urandom % 5 == 0) begin
            @(posedge clk); #1;
         end
      end
      rnd_ready_en = 1'b0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain_queue_empty", exp_q.size(), 0);
      chk("drain_out_valid", out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bitwise_logic_unit.md
# bitwise_logic_unit

Parametrised, registered bitwise logic unit: the successor to the two-input single-bit OR gate, generalised to WIDTH-bit operands, eight selectable operations, a valid/ready handshake and a multi-beat accumulate (reduction) mode. It sits in the datapath next to the ALU and provides masked-flag and reduction operations. Results are registered, with one cycle of latency and a throughput of one result per cycle.

## Interface
- WIDTH, 8: operand and result width in bits.
- CNT_W, 4: width of the beat counter, which saturates.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- X  in  WIDTH  operand A.
- Y  in  WIDTH  operand B; used only on the first beat of a burst.
- OP  in  3  operation: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT X, 7 PASS X.
- ACC  in  1  on the first beat, 1 opens a multi-beat burst.
- LAST  in  1  marks the final beat of a burst; ignored when ACC=0 on the first beat.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- OUT  out  WIDTH  result.
- ZERO  out  1  OUT == 0, registered with OUT.
- BEAT_CNT  out  CNT_W  number of beats combined into OUT, saturating.

## Operation
- A beat transfers when in_valid && in_ready. A result transfers when out_valid && out_ready.
- in_ready = (!out_valid || out_ready). The unit accepts a beat in the same cycle the held result drains.
- The unit has three states: IDLE, ACCUM and HOLD.
  - "HOLD" here means out_valid=1.
  - ACCUM is orthogonal to HOLD: a burst can begin while the previous result is draining.
- First beat (IDLE):
  - The unit computes r = op(X, Y) and latches OP internally for the burst.
  - If ACC=0, or ACC=1 with LAST=1: OUT<=r, ZERO<=(r==0), BEAT_CNT<=1, out_valid<=1, and the state stays IDLE.
  - If ACC=1 with LAST=0: acc<=r, cnt<=1, and the state goes to ACCUM.
- Continuation beat (ACCUM):
  - acc<=op_latched(acc, X). The unit ignores Y, OP and ACC on continuation beats.
  - cnt<=cnt+1, saturating at 2^CNT_W-1.
  - If LAST=1: the final value goes to OUT with out_valid<=1, and the state goes to IDLE.
- Unary ops (NOT, PASS) in accumulate mode:
  - The first beat applies the op to X.
  - Continuation beats use op(acc, X): NOT gives ~X and PASS gives X, i.e. the last beat wins.
- out_valid clears on result transfer unless a new LAST or single beat is accepted in the same cycle. In that case out_valid stays 1 and OUT updates.
- While out_valid=1 and out_ready=0, OUT, ZERO and BEAT_CNT hold stable.
- Reset values: out_valid=0, OUT=0, ZERO=0, BEAT_CNT=0, state IDLE, acc=0, cnt=0. in_ready is 1 out of reset.
- Reset asserted mid-burst discards the accumulator and counter with no output.

## Timing
- Latency: a LAST or single beat accepted at edge N gives out_valid=1 with the result after edge N.
- Throughput: one beat per cycle while out_ready=1.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from in_valid to out_valid.
- Simultaneous drain and accept: the new result overwrites OUT at the same edge with no bubble.
- Backpressure: with out_ready=0 and out_valid=1, in_ready=0, including during ACCUM. A burst therefore stalls but does not lose beats.
- Counter saturation: BEAT_CNT reads 2^CNT_W-1 for any burst of at least 2^CNT_W-1 beats.

## Structure
- Package logic_unit_pkg holds:
  - the op_e enum (3-bit, values above);
  - the state_e enum (IDLE, ACCUM).
- Sub-module bitwise_op: purely combinational, parametrised on WIDTH. Inputs are op_e, a and b; output is y. It is instantiated once.
  - The first/continuation mux selects (X, Y) or (acc, X) into it.
- The top level holds the state register, the acc/cnt registers, the output register and the handshake logic.

## Test plan
All scenarios use WIDTH=8 unless noted.
- Reset: drive rst_n=0 during the second beat of a burst, then release → out_valid=0, OUT=0, BEAT_CNT=0, in_ready=1. No result appears for the aborted burst.
- Single OR: X=8'hA0, Y=8'h0F, OP=1, ACC=0 → next cycle out_valid=1, OUT=8'hAF, ZERO=0, BEAT_CNT=1.
- XOR burst:
  - beats: (X=8'h0F, Y=8'hF0, ACC=1), (X=8'hFF), (X=8'h0F, LAST=1), with OP=2;
  - expected: OUT=8'h0F, BEAT_CNT=3. The intermediate zero does not raise out_valid.
- Backpressure:
  - stimulus: out_ready=0 for 3 cycles after a result (AND 8'hF0 & 8'h3C), with a second beat held valid;
  - expected: OUT=8'h30 stable, in_ready=0, second beat accepted only on the cycle out_ready rises.
- Back-to-back:
  - stimulus: out_ready=1; AND(8'hF0, 8'h3C) then NOR(8'h00, 8'h00) on consecutive cycles;
  - expected: OUT=8'h30 then 8'hFF on consecutive cycles with no bubble. The NOR result is 8'hFF, so ZERO=0.
- Saturation: CNT_W=2, 5-beat AND burst with all X=8'hFF, Y=8'h81 → OUT=8'h81, BEAT_CNT=3.
